reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_if.sv | 23 ++
 rtl/reset_sequencer.sv | 116 +++++++++++
 tb/tb_reset_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer handshake: the debounced press pulse in, datapath reset, ready flag and debug counter out.
interface reset_sequencer_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   press;
  logic                   sys_reset_n;
  logic                   ready;
  logic [COUNT_WIDTH-1:0] reset_count;

  modport master (
    input  press,
    output sys_reset_n,
    output ready,
    output reset_count
  );

  modport slave (
    output press,
    input  sys_reset_n,
    input  ready,
    input  reset_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Turns a press pulse (or board reset release) into a stretched active-low datapath reset,
// a settle window and a ready flag; counts accepted manual presses with saturation.
module reset_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    SETTLE = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [15:0]            cnt;
  logic [15:0]            cnt_next;
  logic                   press_q;
  logic                   press_event;
  logic                   count_inc;
  logic                   sys_reset_n_d;
  logic                   ready_d;
  logic                   sys_reset_n_q;
  logic                   ready_q;
  logic [COUNT_WIDTH-1:0] count_q;

  // A press held high across many cycles is a single event.
  assign press_event = bus.press & ~press_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ASSERT;
      cnt     <= '0;
      press_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      press_q <= bus.press;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_inc  = 1'b0;
    case (state)
      ASSERT: begin
        if (cnt == HOLD_LAST) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      SETTLE: begin
        // A press beats a simultaneous settle timeout.
        if (press_event) begin
          state_next = ASSERT;
          cnt_next   = '0;
          count_inc  = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      READY: begin
        cnt_next = '0;
        if (press_event) begin
          state_next = ASSERT;
          count_inc  = 1'b1;
        end
      end
      default: begin
        state_next = ASSERT;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they can be registered without an extra cycle of lag.
  always_comb begin
    sys_reset_n_d = (state_next != ASSERT);
    ready_d       = (state_next == READY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      count_q       <= '0;
    end else begin
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      if (count_inc && (count_q != {COUNT_WIDTH{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.ready       = ready_q;
  assign bus.reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Drives two sequencers (16/8 with a 2-bit counter, and 1/1 with an 8-bit counter) from one press
// line and compares every cycle against a timeline model built from the sequence start edge.
module tb_reset_sequencer;

  logic clock;
  logic reset_n;
  logic press;

  int checks;
  int errors;

  reset_sequencer_if #(.COUNT_WIDTH(2)) bus_a ();
  reset_sequencer_if #(.COUNT_WIDTH(8)) bus_b ();

  assign bus_a.press = press;
  assign bus_b.press = press;

  reset_sequencer #(.HOLD_CYCLES(16), .SETTLE_CYCLES(8), .COUNT_WIDTH(2)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a.master)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .SETTLE_CYCLES(1), .COUNT_WIDTH(8)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b.master)
  );

  int obs_sys [2];
  int obs_rdy [2];
  int obs_cnt [2];

  always_comb begin
    obs_sys[0] = int'(bus_a.sys_reset_n);
    obs_rdy[0] = int'(bus_a.ready);
    obs_cnt[0] = int'(bus_a.reset_count);
    obs_sys[1] = int'(bus_b.sys_reset_n);
    obs_rdy[1] = int'(bus_b.ready);
    obs_cnt[1] = int'(bus_b.reset_count);
  end

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Timeline model: a sequence started at edge s holds the datapath in reset while
  // (edge - s) < HOLD, then settles until (edge - s) >= HOLD + SETTLE. A press edge is
  // accepted only once the hold period of the current sequence has fully elapsed.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int HOLD   = (g == 0) ? 16 : 1;
    localparam int SETTLE = (g == 0) ? 8  : 1;
    localparam int CMAX   = (g == 0) ? 3  : 255;

    int  edge_n;
    int  start;
    int  count;
    bit  press_prev;

    always @(negedge reset_n) begin
      edge_n     = 0;
      start      = 0;
      count      = 0;
      press_prev = 1'b0;
    end

    always @(posedge clock) begin
      if (reset_n) begin
        bit ev;
        edge_n++;
        ev         = press && !press_prev;
        press_prev = press;
        if (ev && (edge_n > start + HOLD)) begin
          start = edge_n;
          if (count < CMAX) count++;
        end
        #1;
        check((g == 0) ? "a_sys_reset_n" : "b_sys_reset_n", obs_sys[g],
              ((edge_n - start) >= HOLD) ? 1 : 0);
        check((g == 0) ? "a_ready" : "b_ready", obs_rdy[g],
              ((edge_n - start) >= HOLD + SETTLE) ? 1 : 0);
        check((g == 0) ? "a_reset_count" : "b_reset_count", obs_cnt[g], count);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int len);
    @(negedge clock);
    press = 1'b1;
    wait_cycles(len);
    press = 1'b0;
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_a_sys"}, obs_sys[0], 0);
    check({tag, "_a_rdy"}, obs_rdy[0], 0);
    check({tag, "_a_cnt"}, obs_cnt[0], 0);
    check({tag, "_b_sys"}, obs_sys[1], 0);
    check({tag, "_b_rdy"}, obs_rdy[1], 0);
    check({tag, "_b_cnt"}, obs_cnt[1], 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    press   = 1'b0;
    reset_n = 1'b0;
    #35;
    check_in_reset("por");
    @(negedge clock);
    reset_n = 1'b1;

    // Power-on sequence, then a single press from READY.
    wait_cycles(30);
    pulse(1);
    wait_cycles(30);

    // Press held for 100 cycles: one sequence only.
    pulse(100);
    wait_cycles(30);

    // Press during ASSERT (ignored), then a press during SETTLE (restarts).
    pulse(1);
    wait_cycles(4);
    pulse(1);
    wait_cycles(14);
    pulse(1);
    wait_cycles(30);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 6; i++) begin
      pulse(1);
      wait_cycles(26);
    end

    // Randomised press activity.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) pulse($urandom_range(1, 4));
      else wait_cycles(1);
    end
    wait_cycles(30);

    // Asynchronous board reset in the middle of SETTLE, between clock edges.
    pulse(1);
    wait_cycles(19);
    @(posedge clock);
    #5;
    reset_n = 1'b0;
    #1;
    check_in_reset("async");
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(30);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
